frost32_mmio_timer: RTL

//  Memory-mapped countdown timer on the Frost32Cpu data bus; the responder end of the CPU

---
 rtl/frost32_mmio_timer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/frost32_mmio_timer.sv
// rtl/frost32_mmio_timer.sv - memory-mapped countdown timer on the Frost32 data bus
//
// Responds to CPU accesses that fall inside a small register window at BASE_ADDR
// (CTRL, COUNT, RELOAD, STATUS). It stalls the CPU for ACCESS_LATENCY cycles per
// access and drives a level interrupt when the counter expires.
//
// Optional feature macro: FROST32_TIMER_PRESCALER_EN
//   Adds the PRESCALE register at offset 0x10 so that COUNT ticks once every
//   PRESCALE+1 enabled cycles. When the macro is undefined, COUNT ticks every
//   enabled cycle and the window covers offsets 0x0..0xF only.
//
// Ports:
//   clk                     in   rising-edge clock
//   rst_n                   in   asynchronous active-low reset
//   req_mem_access          in   CPU access request
//   addr                    in   byte address
//   data_in                 in   CPU write data (sub-word data in the low bits)
//   data_inout_access_type  in   0 = read, 1 = write
//   data_inout_access_size  in   0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = 32-bit
//   data_out                out  read data, 0 unless finishing a read
//   wait_for_mem            out  CPU stall while the access is in progress
//   interrupt               out  registered expired & irq_en
//   selected                out  high while this block owns the current access
module frost32_mmio_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int unsigned ACCESS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_mem_access,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        data_inout_access_type,
    input  logic [1:0]  data_inout_access_size,
    output logic [31:0] data_out,
    output logic        wait_for_mem,
    output logic        interrupt,
    output logic        selected
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef FROST32_TIMER_PRESCALER_EN
    localparam logic [31:0] WINDOW_BYTES = 32'd20;
    localparam logic [2:0]  LAST_WORD    = 3'd4;
`else
    localparam logic [31:0] WINDOW_BYTES = 32'd16;
    localparam logic [2:0]  LAST_WORD    = 3'd3;
`endif

    localparam logic [3:0] LAT_M1 = 4'(ACCESS_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [4:0]  off_q, off_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_out_q, data_out_d;

    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        auto_reload_q, auto_reload_d;
    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        expired_q, expired_d;
    logic        irq_q, irq_d;
`ifdef FROST32_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
`endif

    logic [31:0] addr_off;
    logic        hit;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic        aligned;
    logic        mapped;
    logic [31:0] wr_lane;
    logic [31:0] reg_word;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic        commit;
    logic        do_wr;
    logic        tick_ok;
    logic        tick;
    logic        expire;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to large offsets,
    // so a single compare covers both ends of the window.
    assign addr_off = addr - BASE_ADDR;
    assign hit      = (addr_off < WINDOW_BYTES);

    // Lane selection, alignment and register mux for the latched access.
    always_comb begin
        lane_shift = {off_q[1:0], 3'b000};
        case (size_q)
            2'd1: begin
                lane_mask = 32'h0000_FFFF << lane_shift;
                aligned   = ~off_q[0];
            end
            2'd2: begin
                lane_mask = 32'h0000_00FF << lane_shift;
                aligned   = 1'b1;
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                aligned   = (off_q[1:0] == 2'b00);
            end
        endcase
        wr_lane = wdata_q << lane_shift;
        mapped  = (off_q[4:2] <= LAST_WORD);
        case (off_q[4:2])
            3'd0:    reg_word = {29'd0, auto_reload_q, irq_en_q, en_q};
            3'd1:    reg_word = count_q;
            3'd2:    reg_word = reload_q;
            3'd3:    reg_word = {31'd0, expired_q};
`ifdef FROST32_TIMER_PRESCALER_EN
            3'd4:    reg_word = {16'd0, prescale_q};
`endif
            default: reg_word = 32'd0;
        endcase
        rd_word = (aligned && mapped) ? ((reg_word & lane_mask) >> lane_shift) : 32'd0;
        merged  = (reg_word & ~lane_mask) | (wr_lane & lane_mask);
    end

    assign commit = (state_q == ST_BUSY) && (busy_cnt_q == 4'd0);
    assign do_wr  = commit && wr_q && aligned && mapped;

    // Bus handshake FSM.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        off_d      = off_q;
        wr_d       = wr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        data_out_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req_mem_access && hit) begin
                    state_d    = ST_BUSY;
                    busy_cnt_d = LAT_M1;
                    off_d      = addr_off[4:0];
                    wr_d       = data_inout_access_type;
                    size_d     = data_inout_access_size;
                    wdata_d    = data_in;
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == 4'd0) begin
                    state_d    = ST_DONE;
                    data_out_d = wr_q ? 32'd0 : rd_word;
                end else begin
                    busy_cnt_d = busy_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter, expiry and register writes. CPU writes are applied after the tick
    // so a COUNT or CTRL write overrides the tick; a STATUS clear loses to expiry.
    always_comb begin
        en_d          = en_q;
        irq_en_d      = irq_en_q;
        auto_reload_d = auto_reload_q;
        count_d       = count_q;
        reload_d      = reload_q;
        expired_d     = expired_q;
        irq_d         = expired_q & irq_en_q;
`ifdef FROST32_TIMER_PRESCALER_EN
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        tick_ok    = (pre_cnt_q == prescale_q);
        if (!en_q) begin
            pre_cnt_d = 16'd0;
        end else if (count_q != 32'd0) begin
            pre_cnt_d = tick_ok ? 16'd0 : pre_cnt_q + 16'd1;
        end
`else
        tick_ok = 1'b1;
`endif
        tick   = en_q && (count_q != 32'd0) && tick_ok;
        expire = tick && (count_q == 32'd1);
        if (tick) begin
            count_d = expire ? (auto_reload_q ? reload_q : 32'd0) : count_q - 32'd1;
        end
        if (expire) begin
            expired_d = 1'b1;
            if (!auto_reload_q) begin
                en_d = 1'b0;
            end
        end
        if (do_wr) begin
            case (off_q[4:2])
                3'd0: begin
                    en_d          = merged[0];
                    irq_en_d      = merged[1];
                    auto_reload_d = merged[2];
                end
                3'd1: begin
                    count_d = merged;
`ifdef FROST32_TIMER_PRESCALER_EN
                    pre_cnt_d = 16'd0;
`endif
                end
                3'd2: reload_d = merged;
                3'd3: begin
                    if (lane_mask[0] && wr_lane[0] && !expire) begin
                        expired_d = 1'b0;
                    end
                end
`ifdef FROST32_TIMER_PRESCALER_EN
                3'd4: prescale_d = merged[15:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_cnt_q    <= 4'd0;
            off_q         <= 5'd0;
            wr_q          <= 1'b0;
            size_q        <= 2'd0;
            wdata_q       <= 32'd0;
            data_out_q    <= 32'd0;
            en_q          <= 1'b0;
            irq_en_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            count_q       <= 32'd0;
            reload_q      <= 32'd0;
            expired_q     <= 1'b0;
            irq_q         <= 1'b0;
`ifdef FROST32_TIMER_PRESCALER_EN
            prescale_q    <= 16'd0;
            pre_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            off_q         <= off_d;
            wr_q          <= wr_d;
            size_q        <= size_d;
            wdata_q       <= wdata_d;
            data_out_q    <= data_out_d;
            en_q          <= en_d;
            irq_en_q      <= irq_en_d;
            auto_reload_q <= auto_reload_d;
            count_q       <= count_d;
            reload_q      <= reload_d;
            expired_q     <= expired_d;
            irq_q         <= irq_d;
`ifdef FROST32_TIMER_PRESCALER_EN
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
`endif
        end
    end

    assign data_out     = data_out_q;
    assign wait_for_mem = (state_q == ST_BUSY);
    assign selected     = (state_q != ST_IDLE);
    assign interrupt    = irq_q;

endmodule
